// File: rtl/mmio_sampler_core.sv
`default_nettype none
// ============================================================================
// mmio_sampler_core -- N_CH x W-bit tick-driven sampler feeding a tagged FIFO
//                      drained over the MMIO slot bus, with a threshold IRQ.
// Optional feature macro: SAMPLER_TRIG_EN (external trigger arms the sampler)
// Revision: 1.0
// ============================================================================

module mmio_sampler_core #(
  parameter int N_CH  = 4,
  parameter int W     = 12,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [4:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  input  logic [N_CH*W-1:0] din,
`ifdef SAMPLER_TRIG_EN
  input  logic              trig,
`endif
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SCAN  = 2'd2,
    S_ARMED = 2'd3
  } state_t;

  state_t          state;
  logic            run;
  logic            irq_en;
  logic [31:0]     period;
  logic [31:0]     thresh;
  logic [31:0]     cnt;
  logic [N_CH-1:0] mask;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   sel;
  logic            found;
  logic            more;
  logic [W-1:0]    sample;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overrun;
  logic [31:0]     mem [DEPTH];

  logic        reg_wr, clear, pop, push, push_ok, drop, full, empty, active, tick;
  logic [31:0] pmax, status, push_word;
  logic        unused_addr;

  assign reg_wr      = cs & write;
  assign clear       = reg_wr && (addr[2:0] == 3'd2) && wr_data[1];
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign pop         = cs && read && (addr[2:0] == 3'd0) && !empty;
  assign pmax        = (period == 32'd0) ? 32'd1 : period;
  assign active      = run && ((state == S_WAIT) || (state == S_SCAN));
  assign tick        = active && (cnt >= pmax - 32'd1);
  assign push        = run && (state == S_SCAN) && found;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign push_ok     = push && (!full || pop);
  assign drop        = push && full && !pop;
  assign push_word   = {sel[3:0], 28'(sample)};
  assign status      = {overrun, full, empty, state, {(27-CW){1'b0}}, count};
  assign unused_addr = ^addr[4:3];

`ifdef SAMPLER_TRIG_EN
  logic [2:0] trig_sync;
  logic       trig_rise;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trig_sync <= '0;
    else          trig_sync <= {trig_sync[1:0], trig};
  end
  assign trig_rise = trig_sync[1] & ~trig_sync[2];
`endif

  // Lowest enabled channel at or above scan_idx, and whether any enabled one remains above it.
  always_comb begin
    found  = 1'b0;
    more   = 1'b0;
    sel    = '0;
    sample = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (mask[k] && (IW'(k) >= scan_idx)) begin
        if (!found) begin
          found  = 1'b1;
          sel    = IW'(k);
          sample = din[k*W +: W];
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run    <= 1'b0;
      irq_en <= 1'b0;
      period <= '0;
      mask   <= '0;
      thresh <= '0;
    end else if (reg_wr) begin
      case (addr[2:0])
        3'd2: begin
          run    <= wr_data[0];
          irq_en <= wr_data[2];
        end
        3'd3:    period <= wr_data;
        3'd4:    mask   <= wr_data[N_CH-1:0];
        3'd5:    thresh <= wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      scan_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
    end else begin
      if (!run) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
`ifdef SAMPLER_TRIG_EN
            state <= S_ARMED;
`else
            state <= S_WAIT;
`endif
            cnt <= '0;
          end
`ifdef SAMPLER_TRIG_EN
          S_ARMED: begin
            if (trig_rise) begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
`endif
          S_WAIT: begin
            cnt <= tick ? 32'd0 : cnt + 32'd1;
            if (tick) begin
              state    <= S_SCAN;
              scan_idx <= '0;
            end
          end
          S_SCAN: begin
            cnt <= tick ? 32'd0 : cnt + 32'd1;
            if (found) scan_idx <= sel + IW'(1);
            if (!found || !more) state <= S_WAIT;
          end
          default: state <= S_IDLE;
        endcase
      end

      if (clear) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        overrun <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      count <= count + CW'(1);
        else if (pop && !push_ok) count <= count - CW'(1);
        if (drop || (tick && (state == S_SCAN))) overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_en && (32'(count) >= thresh) && (thresh != 32'd0);
  end

  always_comb begin
    rd_data = '0;
    case (addr[2:0])
      3'd0:    if (!empty) rd_data = mem[rd_ptr];
      3'd1:    rd_data = status;
      default: rd_data = '0;
    endcase
  end

endmodule

`default_nettype wire
